// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
//   Round-robin arbiter for the shared address/data bus. Each master raises
//   request; the arbiter answers with a registered one-hot grant, follows the
//   granted master's transaction on the bus begin/end lines, and takes the bus
//   back when the transaction ends, when the master gives up before beginning,
//   or when it never begins within GRANT_TIMEOUT cycles.
//
//   Optional feature (macro BUS_ARBITER_WATCHDOG_EN): a watchdog aborts an
//   active transaction after WATCHDOG_CYCLES cycles without bus activity.
//   In the abort cycle the arbiter drives endTransactionOut and busErrorOut.
//   When the macro is undefined the watchdog is absent and both outputs are 0.
//
// Ports
//   clock              system clock
//   reset              asynchronous, active-low reset
//   request            per-master requestTransaction
//   grant              one-hot transactionGranted (registered)
//   activeMaster       index of granted master, valid while busActive=1
//   busActive          high from grant until the transaction is released
//   beginTransactionIn bus begin-transaction line
//   endTransactionIn   bus end-transaction line
//   dataValidIn        bus data-valid line (watchdog activity)
//   busErrorIn         bus error line (does not end a transaction)
//   endTransactionOut  arbiter-driven end on watchdog abort
//   busErrorOut        arbiter-driven error on watchdog abort
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus free; arbitrate among requests
// GRANTED | grant issued, waiting for the master to begin
// ACTIVE  | transaction in progress; grant held until end
// ABORT   | watchdog abort cycle (watchdog build only)
// RELEASE | grant dropped; one turnaround cycle before IDLE

module bus_arbiter_rr #(
  parameter int NR_MASTERS      = 4,
  parameter int GRANT_TIMEOUT   = 16,
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_MASTERS-1:0] request,
  output logic [NR_MASTERS-1:0] grant,
  output logic [2:0]            activeMaster,
  output logic                  busActive,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  dataValidIn,
  input  logic                  busErrorIn,
  output logic                  endTransactionOut,
  output logic                  busErrorOut
);

  localparam int IDX_W  = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int WAIT_W = $clog2(GRANT_TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANTED = 3'd1;
  localparam logic [2:0] ACTIVE  = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam logic [2:0] ABORT   = 3'd4;
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] watchdogCount;
`endif

  logic [2:0]            state;
  logic [2:0]            lastGrant;
  logic [WAIT_W-1:0]     waitCount;
  logic                  pickValid;
  logic [2:0]            pickIdx;
  logic                  requestHeld;
  logic [NR_MASTERS-1:0] pickOneHot;
  int                    idx;

  // Busy-error is informational only; it never changes the arbitration.
  logic unusedInputs;
  assign unusedInputs = ^{busErrorIn, dataValidIn, WATCHDOG_CYCLES[0]};

  // Still-requesting check for the granted master, without indexing by
  // activeMaster (the grant vector already marks it).
  assign requestHeld = |(request & grant);

  // Round-robin search: walk offsets from farthest to nearest so the nearest
  // requester after lastGrant is the one left standing.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    idx       = 0;
    for (int k = NR_MASTERS; k >= 1; k--) begin
      idx = (int'(lastGrant) + k) % NR_MASTERS;
      if (request[idx[IDX_W-1:0]]) begin
        pickValid = 1'b1;
        pickIdx   = 3'(idx);
      end
    end
  end

  assign pickOneHot = {{(NR_MASTERS-1){1'b0}}, 1'b1} << pickIdx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= '0;
      busActive    <= 1'b0;
      activeMaster <= '0;
      lastGrant    <= 3'(NR_MASTERS - 1);
      waitCount    <= '0;
`ifdef BUS_ARBITER_WATCHDOG_EN
      watchdogCount     <= '0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            grant        <= pickOneHot;
            activeMaster <= pickIdx;
            busActive    <= 1'b1;
            lastGrant    <= pickIdx;
            waitCount    <= '0;
            state        <= GRANTED;
          end
        end
        GRANTED: begin
          if (beginTransactionIn) begin
            state <= ACTIVE;
`ifdef BUS_ARBITER_WATCHDOG_EN
            watchdogCount <= '0;
`endif
          end else if (!requestHeld || waitCount == WAIT_W'(GRANT_TIMEOUT - 1)) begin
            grant     <= '0;
            busActive <= 1'b0;
            state     <= RELEASE;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end
        ACTIVE: begin
          if (endTransactionIn) begin
            grant     <= '0;
            busActive <= 1'b0;
            state     <= RELEASE;
          end
`ifdef BUS_ARBITER_WATCHDOG_EN
          else if (watchdogCount == WD_W'(WATCHDOG_CYCLES - 1)) begin
            endTransactionOut <= 1'b1;
            busErrorOut       <= 1'b1;
            state             <= ABORT;
          end else if (dataValidIn || beginTransactionIn) begin
            watchdogCount <= '0;
          end else begin
            watchdogCount <= watchdogCount + 1'b1;
          end
`endif
        end
`ifdef BUS_ARBITER_WATCHDOG_EN
        ABORT: begin
          endTransactionOut <= 1'b0;
          busErrorOut       <= 1'b0;
          grant             <= '0;
          busActive         <= 1'b0;
          state             <= RELEASE;
        end
`endif
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUS_ARBITER_WATCHDOG_EN
  assign endTransactionOut = 1'b0;
  assign busErrorOut       = 1'b0;
`endif

endmodule
